// File: rtl/csr_pkg.sv
// Shared CSR numbers, read-only constant values and reset values for csr_file.
package csr_pkg;

    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    localparam logic [31:0] VAL_MVENDORID = 32'h5256_4B43;
    localparam logic [31:0] VAL_MARCHID   = 32'h3436_5335;
    localparam logic [31:0] VAL_MIMPID    = 32'h3436_4931;
    localparam logic [31:0] VAL_MHARTID   = 32'h524B_4330;
    localparam logic [31:0] VAL_MSTATUS   = 32'h0000_1800;
    localparam logic [31:0] VAL_MISA      = 32'h4000_0100;

    localparam logic [31:0] RST_MTVEC    = 32'h0000_1000;
    localparam logic [31:0] RST_MSCRATCH = 32'h0000_0000;
    localparam logic [31:0] RST_MEPC     = 32'h0000_0000;
    localparam logic [31:0] RST_MCAUSE   = 32'h0000_0000;
    localparam logic [63:0] RST_COUNTER  = 64'h0;

endpackage

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read port, synchronous write port, 64-bit counters.
// Optional mscratch at 0x340 when CSR_MSCRATCH_EN is defined.
module csr_file
    import csr_pkg::*;
#(
    parameter int unsigned    XLEN        = 32,
    parameter logic [31:0]    MTVEC_RESET = RST_MTVEC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            trapped,
    input  logic            csr_write_enable,
    input  logic [11:0]     csr_read_address,
    input  logic [11:0]     csr_write_address,
    input  logic [XLEN-1:0] csr_write_data,
    output logic [XLEN-1:0] csr_read_out,
    output logic            csr_ready
);

    logic [XLEN-1:0]   mtvec;
    logic [XLEN-1:0]   mepc;
    logic [XLEN-1:0]   mcause;
    logic [2*XLEN-1:0] mcycle;
    logic [2*XLEN-1:0] minstret;
`ifdef CSR_MSCRATCH_EN
    logic [XLEN-1:0]   mscratch;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            csr_ready <= 1'b0;
        end else begin
            csr_ready <= ~trapped;
        end
    end

    // Reset wins over a coincident write; counters change only via the write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtvec    <= MTVEC_RESET;
            mepc     <= RST_MEPC;
            mcause   <= RST_MCAUSE;
            mcycle   <= RST_COUNTER;
            minstret <= RST_COUNTER;
`ifdef CSR_MSCRATCH_EN
            mscratch <= RST_MSCRATCH;
`endif
        end else if (csr_write_enable) begin
            case (csr_write_address)
                ADDR_MTVEC:     mtvec                 <= csr_write_data;
                ADDR_MEPC:      mepc                  <= csr_write_data;
                ADDR_MCAUSE:    mcause                <= csr_write_data;
                ADDR_MCYCLE:    mcycle[XLEN-1:0]      <= csr_write_data;
                ADDR_MCYCLEH:   mcycle[2*XLEN-1:XLEN] <= csr_write_data;
                ADDR_MINSTRET:  minstret[XLEN-1:0]    <= csr_write_data;
                ADDR_MINSTRETH: minstret[2*XLEN-1:XLEN] <= csr_write_data;
`ifdef CSR_MSCRATCH_EN
                ADDR_MSCRATCH:  mscratch              <= csr_write_data;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        csr_read_out = '0;
        case (csr_read_address)
            ADDR_MVENDORID: csr_read_out = VAL_MVENDORID;
            ADDR_MARCHID:   csr_read_out = VAL_MARCHID;
            ADDR_MIMPID:    csr_read_out = VAL_MIMPID;
            ADDR_MHARTID:   csr_read_out = VAL_MHARTID;
            ADDR_MSTATUS:   csr_read_out = VAL_MSTATUS;
            ADDR_MISA:      csr_read_out = VAL_MISA;
            ADDR_MTVEC:     csr_read_out = mtvec;
            ADDR_MEPC:      csr_read_out = mepc;
            ADDR_MCAUSE:    csr_read_out = mcause;
            ADDR_MCYCLE:    csr_read_out = mcycle[XLEN-1:0];
            ADDR_MCYCLEH:   csr_read_out = mcycle[2*XLEN-1:XLEN];
            ADDR_MINSTRET:  csr_read_out = minstret[XLEN-1:0];
            ADDR_MINSTRETH: csr_read_out = minstret[2*XLEN-1:XLEN];
`ifdef CSR_MSCRATCH_EN
            ADDR_MSCRATCH:  csr_read_out = mscratch;
`endif
            default:        csr_read_out = '0;
        endcase
    end

endmodule

// File: tb/tb_csr_file.sv
// Directed, table-driven bench for csr_file plus hand sequences for ready/trap/reset.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        trapped;
    logic        csr_write_enable;
    logic [11:0] csr_read_address;
    logic [11:0] csr_write_address;
    logic [31:0] csr_write_data;
    logic [31:0] csr_read_out;
    logic        csr_ready;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    typedef struct {
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [11:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[25];

`ifdef CSR_MSCRATCH_EN
    localparam logic [31:0] EXP_MSCRATCH = 32'h1111_2222;
`else
    localparam logic [31:0] EXP_MSCRATCH = 32'h0000_0000;
`endif

    csr_file #(.XLEN(32), .MTVEC_RESET(32'h0000_1000)) dut (
        .clk               (clk),
        .reset             (reset),
        .trapped           (trapped),
        .csr_write_enable  (csr_write_enable),
        .csr_read_address  (csr_read_address),
        .csr_write_address (csr_write_address),
        .csr_write_data    (csr_write_data),
        .csr_read_out      (csr_read_out),
        .csr_ready         (csr_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic read_check(input string name, input logic [11:0] addr, input logic [31:0] exp);
        csr_read_address = addr;
        #1;
        check(name, csr_read_out, exp);
    endtask

    function automatic vec_t mk(input logic we, input logic [11:0] wa, input logic [31:0] wd,
                                input logic [11:0] ra, input logic [31:0] ex);
        vec_t v;
        v.we = we; v.waddr = wa; v.wdata = wd; v.raddr = ra; v.exp = ex;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Each vector's read is sampled before the edge that commits its write.
        vecs[0]  = mk(0, 12'h000, 32'h0,         12'hF11, 32'h5256_4B43);
        vecs[1]  = mk(0, 12'h000, 32'h0,         12'hF12, 32'h3436_5335);
        vecs[2]  = mk(0, 12'h000, 32'h0,         12'hF13, 32'h3436_4931);
        vecs[3]  = mk(0, 12'h000, 32'h0,         12'hF14, 32'h524B_4330);
        vecs[4]  = mk(0, 12'h000, 32'h0,         12'h300, 32'h0000_1800);
        vecs[5]  = mk(0, 12'h000, 32'h0,         12'h301, 32'h4000_0100);
        vecs[6]  = mk(0, 12'h000, 32'h0,         12'h305, 32'h0000_1000);
        vecs[7]  = mk(0, 12'h000, 32'h0,         12'h341, 32'h0000_0000);
        vecs[8]  = mk(0, 12'h000, 32'h0,         12'h342, 32'h0000_0000);
        vecs[9]  = mk(1, 12'h305, 32'h0000_3000, 12'h305, 32'h0000_1000);
        vecs[10] = mk(1, 12'h341, 32'h0000_4000, 12'h305, 32'h0000_3000);
        vecs[11] = mk(1, 12'h342, 32'h0000_0004, 12'h341, 32'h0000_4000);
        vecs[12] = mk(1, 12'hF11, 32'h0000_3000, 12'h342, 32'h0000_0004);
        vecs[13] = mk(1, 12'h7C0, 32'h0000_1234, 12'hF11, 32'h5256_4B43);
        vecs[14] = mk(1, 12'hB00, 32'h1234_5678, 12'h7C0, 32'h0000_0000);
        vecs[15] = mk(1, 12'hB80, 32'hABCD_EF00, 12'hB00, 32'h1234_5678);
        vecs[16] = mk(1, 12'hB02, 32'hDEAD_BEEF, 12'hB80, 32'hABCD_EF00);
        vecs[17] = mk(1, 12'hB82, 32'hCAFE_BABE, 12'hB02, 32'hDEAD_BEEF);
        vecs[18] = mk(1, 12'h340, 32'h1111_2222, 12'hB82, 32'hCAFE_BABE);
        vecs[19] = mk(1, 12'h301, 32'hFFFF_FFFF, 12'h340, EXP_MSCRATCH);
        vecs[20] = mk(0, 12'h000, 32'h0,         12'h301, 32'h4000_0100);
        vecs[21] = mk(0, 12'h000, 32'h0,         12'hB00, 32'h1234_5678);
        vecs[22] = mk(1, 12'hB00, 32'h0000_0001, 12'hB80, 32'hABCD_EF00);
        vecs[23] = mk(0, 12'h000, 32'h0,         12'hB80, 32'hABCD_EF00);
        vecs[24] = mk(0, 12'h000, 32'h0,         12'hB00, 32'h0000_0001);

        reset = 1'b1; trapped = 1'b0; csr_write_enable = 1'b0;
        csr_read_address = '0; csr_write_address = '0; csr_write_data = '0;
        step(); step(); step();
        check("ready_in_reset", {31'b0, csr_ready}, 32'h0);
        reset = 1'b0;
        #1;
        check("ready_before_first_edge", {31'b0, csr_ready}, 32'h0);
        step();
        check("ready_after_release", {31'b0, csr_ready}, 32'h1);

        for (int i = 0; i < 25; i++) begin
            csr_write_enable  = vecs[i].we;
            csr_write_address = vecs[i].waddr;
            csr_write_data    = vecs[i].wdata;
            csr_read_address  = vecs[i].raddr;
            #1;
            check($sformatf("vec%0d_rd_%03h", i, vecs[i].raddr), csr_read_out, vecs[i].exp);
            step();
        end
        csr_write_enable = 1'b0;

        repeat (20) step();
        read_check("idle_mcycle_lo",   12'hB00, 32'h0000_0001);
        read_check("idle_mcycle_hi",   12'hB80, 32'hABCD_EF00);
        read_check("idle_minstret_lo", 12'hB02, 32'hDEAD_BEEF);
        read_check("idle_minstret_hi", 12'hB82, 32'hCAFE_BABE);

        // Trap window: two sampled-high edges, with a write accepted while trapped.
        trapped = 1'b1;
        csr_write_enable = 1'b1; csr_write_address = 12'h342; csr_write_data = 32'h0000_0099;
        #1;
        check("ready_trap_set", {31'b0, csr_ready}, 32'h1);
        step();
        csr_write_enable = 1'b0;
        check("ready_trap_1", {31'b0, csr_ready}, 32'h0);
        read_check("write_while_trapped", 12'h342, 32'h0000_0099);
        step();
        check("ready_trap_2", {31'b0, csr_ready}, 32'h0);
        trapped = 1'b0;
        step();
        check("ready_trap_clear", {31'b0, csr_ready}, 32'h1);

        // Reset with a write pending: reset wins.
        reset = 1'b1;
        csr_write_enable = 1'b1; csr_write_address = 12'h305; csr_write_data = 32'hDEAD_0000;
        step();
        csr_write_enable = 1'b0;
        check("ready_reset_again", {31'b0, csr_ready}, 32'h0);
        read_check("rst_mtvec",    12'h305, 32'h0000_1000);
        read_check("rst_mepc",     12'h341, 32'h0000_0000);
        read_check("rst_mcause",   12'h342, 32'h0000_0000);
        read_check("rst_mcycle_h", 12'hB80, 32'h0000_0000);
        read_check("rst_minst_l",  12'hB02, 32'h0000_0000);
        read_check("rst_mscratch", 12'h340, 32'h0000_0000);
        reset = 1'b0;
        step();
        check("ready_after_rerelease", {31'b0, csr_ready}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
